slip_tx_encoder: RTL



---
 rtl/slip_tx_encoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/slip_tx_encoder.sv
// SLIP transmit encoder: frames a raw byte stream with 0xC0 delimiters and
// escapes in-band 0xC0/0xDB, feeding one registered byte to the UART TX.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   slip_start/slip_end  one-cycle frame open/close pulses (not handshaked)
//   slip_data/valid/ready raw byte input, valid/ready handshake
//   tx_data/valid/ready  encoded byte output, valid/ready handshake
//   frames_sent          trailing delimiters delivered (wraps)
//   err_orphan           sticky: byte accepted outside any frame
module slip_tx_encoder #(
  parameter bit LEAD_DELIM = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slip_start,
  input  logic             slip_end,
  input  logic [7:0]       slip_data,
  input  logic             slip_valid,
  output logic             slip_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] frames_sent,
  output logic             err_orphan
);

  localparam logic [7:0] END_B = 8'hC0;
  localparam logic [7:0] ESC_B = 8'hDB;
  localparam logic [7:0] ESC_END = 8'hDC;
  localparam logic [7:0] ESC_ESC = 8'hDD;

  logic             out_valid, out_valid_n;
  logic [7:0]       out_data, out_data_n;
  logic             out_is_end, out_is_end_n;
  logic             esc_pend, esc_pend_n;
  logic [7:0]       esc_code, esc_code_n;
  logic             start_pend, start_pend_n;
  logic             end_pend, end_pend_n;
  logic             in_frame, in_frame_n;
  logic [CNT_W-1:0] frames_q, frames_n;
  logic             orphan_q, orphan_n;

  logic load_en;
  logic accept;
  logic special;

  // The tx register is free when empty or being drained this cycle.
  assign load_en = !out_valid || tx_ready;

  // Input is only taken when nothing generated internally is waiting.
  assign slip_ready = !rst && !esc_pend && !end_pend
                    && !start_pend && load_en;

  assign accept  = slip_valid && slip_ready;
  assign special = (slip_data == END_B) || (slip_data == ESC_B);

  assign tx_data     = out_data;
  assign tx_valid    = out_valid;
  assign frames_sent = frames_q;
  assign err_orphan  = orphan_q;

  always_comb begin
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    out_is_end_n = out_is_end;
    esc_pend_n   = esc_pend;
    esc_code_n   = esc_code;
    start_pend_n = start_pend;
    end_pend_n   = end_pend;
    in_frame_n   = in_frame;
    frames_n     = frames_q;
    orphan_n     = orphan_q;

    if (load_en) begin
      unique case (1'b1)
        esc_pend: begin
          out_valid_n  = 1'b1;
          out_data_n   = esc_code;
          out_is_end_n = 1'b0;
          esc_pend_n   = 1'b0;
        end
        !esc_pend && end_pend: begin
          out_valid_n  = 1'b1;
          out_data_n   = END_B;
          out_is_end_n = 1'b1;
          end_pend_n   = 1'b0;
        end
        !esc_pend && !end_pend && start_pend: begin
          out_valid_n  = 1'b1;
          out_data_n   = END_B;
          out_is_end_n = 1'b0;
          start_pend_n = 1'b0;
        end
        accept: begin
          out_valid_n  = 1'b1;
          out_is_end_n = 1'b0;
          if (special) begin
            out_data_n = ESC_B;
            esc_pend_n = 1'b1;
            esc_code_n = (slip_data == END_B) ? ESC_END : ESC_ESC;
          end else begin
            out_data_n = slip_data;
          end
        end
        default: begin
          out_valid_n  = 1'b0;
          out_is_end_n = 1'b0;
        end
      endcase
    end

    // Pulses are sampled every cycle; a new pulse wins over a clear.
    if (slip_end)
      end_pend_n = 1'b1;
    if (slip_start && LEAD_DELIM)
      start_pend_n = 1'b1;

    // Start on the same cycle as end means the new frame is open.
    if (slip_start)
      in_frame_n = 1'b1;
    else if (slip_end)
      in_frame_n = 1'b0;

    if (accept && !in_frame)
      orphan_n = 1'b1;

    if (out_valid && tx_ready && out_is_end)
      frames_n = frames_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_is_end <= 1'b0;
      esc_pend   <= 1'b0;
      esc_code   <= 8'h00;
      start_pend <= 1'b0;
      end_pend   <= 1'b0;
      in_frame   <= 1'b0;
      frames_q   <= '0;
      orphan_q   <= 1'b0;
    end else begin
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      out_is_end <= out_is_end_n;
      esc_pend   <= esc_pend_n;
      esc_code   <= esc_code_n;
      start_pend <= start_pend_n;
      end_pend   <= end_pend_n;
      in_frame   <= in_frame_n;
      frames_q   <= frames_n;
      orphan_q   <= orphan_n;
    end
  end

endmodule
